// File: rtl/plab5_mcore_mem_resp_merge_if.sv
`default_nettype none
// ============================================================================
// Module  : plab5_mcore_mem_resp_merge_if
// Brief   : Handshake bundle for the memory response merge unit.
// Revision: 1.0
// ============================================================================
interface plab5_mcore_mem_resp_merge_if #(
  parameter int p_opaque_nbits = 8,
  parameter int p_data_nbits   = 32
);
  localparam int c_len_nbits  = $clog2(p_data_nbits / 8);
  localparam int c_cmsg_nbits = 3 + p_opaque_nbits + c_len_nbits;

  logic                                 cmsg_val;
  logic                                 cmsg_rdy;
  logic [c_cmsg_nbits-1:0]              cmsg;
  logic                                 cmsg_domain;
  logic                                 data_val;
  logic                                 data_rdy;
  logic [p_data_nbits-1:0]              data;
  logic                                 resp_val;
  logic                                 resp_rdy;
  logic [c_cmsg_nbits+p_data_nbits-1:0] resp_msg;
  logic                                 resp_domain;

  // Master drives requests into the merge unit; slave is the merge unit.
  modport master (
    output cmsg_val, cmsg, cmsg_domain, data_val, data, resp_rdy,
    input  cmsg_rdy, data_rdy, resp_val, resp_msg, resp_domain
  );

  modport slave (
    input  cmsg_val, cmsg, cmsg_domain, data_val, data, resp_rdy,
    output cmsg_rdy, data_rdy, resp_val, resp_msg, resp_domain
  );
endinterface
`default_nettype wire

// File: rtl/plab5_mcore_mem_resp_merge.sv
`default_nettype none
// ============================================================================
// Module  : plab5_mcore_mem_resp_merge
// Brief   : Joins control messages with response data words into one response.
// Revision: 1.0
// ============================================================================
module plab5_mcore_mem_resp_merge #(
  parameter int p_opaque_nbits = 8,
  parameter int p_data_nbits   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  plab5_mcore_mem_resp_merge_if.slave   bus
);

  localparam int c_len_nbits    = $clog2(p_data_nbits / 8);
  localparam int c_cmsg_nbits   = 3 + p_opaque_nbits + c_len_nbits;
  localparam int c_centry_nbits = c_cmsg_nbits + 1;
  localparam int c_nbytes       = p_data_nbits / 8;

  localparam logic [2:0] c_type_read    = 3'd0;
  localparam logic [2:0] c_type_amo_add = 3'd3;
  localparam logic [2:0] c_type_amo_and = 3'd4;
  localparam logic [2:0] c_type_amo_or  = 3'd5;

  // --------------------------------------------------------------------------
  // Control FIFO: {domain, cmsg}, two entries
  // --------------------------------------------------------------------------
  logic [c_centry_nbits-1:0] r_cq_mem [2];
  logic                      r_cq_wptr;
  logic                      r_cq_rptr;
  logic [1:0]                r_cq_count;
  logic                      w_cq_full;
  logic                      w_cq_valid;
  logic                      w_cq_enq;
  logic                      w_cq_deq;

  assign w_cq_full    = (r_cq_count == 2'd2);
  assign w_cq_valid   = (r_cq_count != 2'd0);
  assign bus.cmsg_rdy = !w_cq_full && !reset;
  assign w_cq_enq     = bus.cmsg_val && bus.cmsg_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cq_wptr  <= 1'b0;
      r_cq_rptr  <= 1'b0;
      r_cq_count <= 2'd0;
    end else begin
      if (w_cq_enq) r_cq_wptr <= ~r_cq_wptr;
      if (w_cq_deq) r_cq_rptr <= ~r_cq_rptr;
      r_cq_count <= r_cq_count + {1'b0, w_cq_enq} - {1'b0, w_cq_deq};
    end
  end

  always_ff @(posedge clk) begin
    if (w_cq_enq) r_cq_mem[r_cq_wptr] <= {bus.cmsg_domain, bus.cmsg};
  end

  // --------------------------------------------------------------------------
  // Data FIFO, two entries
  // --------------------------------------------------------------------------
  logic [p_data_nbits-1:0] r_dq_mem [2];
  logic                    r_dq_wptr;
  logic                    r_dq_rptr;
  logic [1:0]              r_dq_count;
  logic                    w_dq_full;
  logic                    w_dq_valid;
  logic                    w_dq_enq;
  logic                    w_dq_deq;

  assign w_dq_full    = (r_dq_count == 2'd2);
  assign w_dq_valid   = (r_dq_count != 2'd0);
  assign bus.data_rdy = !w_dq_full && !reset;
  assign w_dq_enq     = bus.data_val && bus.data_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dq_wptr  <= 1'b0;
      r_dq_rptr  <= 1'b0;
      r_dq_count <= 2'd0;
    end else begin
      if (w_dq_enq) r_dq_wptr <= ~r_dq_wptr;
      if (w_dq_deq) r_dq_rptr <= ~r_dq_rptr;
      r_dq_count <= r_dq_count + {1'b0, w_dq_enq} - {1'b0, w_dq_deq};
    end
  end

  always_ff @(posedge clk) begin
    if (w_dq_enq) r_dq_mem[r_dq_wptr] <= bus.data;
  end

  // --------------------------------------------------------------------------
  // Head decode and merge decision
  // --------------------------------------------------------------------------
  logic [c_centry_nbits-1:0] w_c_head;
  logic [c_cmsg_nbits-1:0]   w_head_cmsg;
  logic                      w_head_domain;
  logic [2:0]                w_head_type;
  logic [c_len_nbits-1:0]    w_head_len;
  logic [p_data_nbits-1:0]   w_d_head;
  logic                      w_needs_data;
  logic                      w_out_free;
  logic                      w_fire;
  logic [p_data_nbits-1:0]   w_resp_data;

  assign w_c_head      = r_cq_mem[r_cq_rptr];
  assign w_head_cmsg   = w_c_head[c_cmsg_nbits-1:0];
  assign w_head_domain = w_c_head[c_cmsg_nbits];
  assign w_head_type   = w_head_cmsg[c_cmsg_nbits-1 -: 3];
  assign w_head_len    = w_head_cmsg[c_len_nbits-1:0];
  assign w_d_head      = r_dq_mem[r_dq_rptr];

  // Only reads and AMOs carry data; write, init and reserved types go alone.
  always_comb begin
    w_needs_data = 1'b0;
    case (w_head_type)
      c_type_read, c_type_amo_add, c_type_amo_and, c_type_amo_or: w_needs_data = 1'b1;
      default:                                                     w_needs_data = 1'b0;
    endcase
  end

  assign w_out_free = !bus.resp_val || bus.resp_rdy;
  assign w_fire     = w_cq_valid && (!w_needs_data || w_dq_valid) && w_out_free;
  assign w_cq_deq   = w_fire;
  assign w_dq_deq   = w_fire && w_needs_data;

  // len==0 keeps the whole word; otherwise only the low len bytes survive.
  always_comb begin
    w_resp_data = '0;
    if (w_needs_data) begin
      for (int i = 0; i < c_nbytes; i++) begin
        if ((w_head_len == '0) || (i < int'(w_head_len)))
          w_resp_data[8*i +: 8] = w_d_head[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output pipeline register
  // --------------------------------------------------------------------------
  logic                                 r_resp_val;
  logic [c_cmsg_nbits+p_data_nbits-1:0] r_resp_msg;
  logic                                 r_resp_domain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_val    <= 1'b0;
      r_resp_msg    <= '0;
      r_resp_domain <= 1'b0;
    end else if (w_fire) begin
      r_resp_val    <= 1'b1;
      r_resp_msg    <= {w_head_cmsg, w_resp_data};
      r_resp_domain <= w_head_domain;
    end else if (bus.resp_rdy) begin
      r_resp_val    <= 1'b0;
    end
  end

  assign bus.resp_val    = r_resp_val;
  assign bus.resp_msg    = r_resp_msg;
  assign bus.resp_domain = r_resp_domain;

endmodule
`default_nettype wire
